// File: rtl/prog_sequence_detector.sv
// Runtime-programmable serial bit-pattern detector with overlap control,
// registered detect pulse and saturating match counter.
module prog_sequence_detector #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               din_valid,
   input  logic               din,
   input  logic               clr_count,
   output logic               detected,
   output logic [CNT_W-1:0]   match_count,
   output logic               cfg_err,
   output logic               armed
);

   typedef enum logic [1:0] {UNCFG, FILL, RUN} state_t;

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

   state_t               state, state_n;
   // Only MAX_LEN-1 old bits are stored: the oldest bit of a full window is
   // shifted out before any compare can see it.
   logic [MAX_LEN-2:0]   history, history_n;
   logic [MAX_LEN-1:0]   hist_shift, len_mask;
   logic [MAX_LEN-1:0]   pattern, pattern_n;
   logic [LEN_W-1:0]     fill, fill_n, fill_inc, len, len_n;
   logic                 overlap, overlap_n;
   logic                 detected_n, cfg_err_n;
   logic [CNT_W-1:0]     count_n;
   logic                 cfg_legal, consume, match;

   always_comb begin
      len_mask = '0;
      for (int unsigned i = 0; i < MAX_LEN; i++)
         len_mask[i] = (i < 32'(len));
   end

   assign cfg_legal  = (cfg_len != '0) && (cfg_len <= LEN_MAX);
   assign hist_shift = {history, din};
   assign fill_inc   = (fill >= LEN_MAX) ? fill : fill + LEN_W'(1);
   assign consume    = din_valid && !cfg_we && (state != UNCFG);
   assign match      = consume && (fill_inc >= len) &&
                       (((hist_shift ^ pattern) & len_mask) == '0);

   always_comb begin
      state_n    = state;
      history_n  = history;
      fill_n     = fill;
      pattern_n  = pattern;
      len_n      = len;
      overlap_n  = overlap;
      detected_n = 1'b0;
      cfg_err_n  = 1'b0;
      count_n    = match_count;

      if (cfg_we) begin
         if (cfg_legal) begin
            state_n   = FILL;
            history_n = '0;
            fill_n    = '0;
            pattern_n = cfg_pattern;
            len_n     = cfg_len;
            overlap_n = cfg_overlap;
         end else begin
            cfg_err_n = 1'b1;
         end
      end else if (consume) begin
         history_n = hist_shift[MAX_LEN-2:0];
         fill_n    = fill_inc;
         state_n   = (fill_inc >= len) ? RUN : FILL;
         if (match) begin
            detected_n = 1'b1;
            if (!overlap) begin
               fill_n  = '0;
               state_n = FILL;
            end
         end
      end

      if (clr_count)
         count_n = match ? CNT_W'(1) : '0;
      else if (match && (match_count != '1))
         count_n = match_count + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= UNCFG;
         history     <= '0;
         fill        <= '0;
         pattern     <= '0;
         len         <= '0;
         overlap     <= 1'b0;
         detected    <= 1'b0;
         cfg_err     <= 1'b0;
         match_count <= '0;
      end else begin
         state       <= state_n;
         history     <= history_n;
         fill        <= fill_n;
         pattern     <= pattern_n;
         len         <= len_n;
         overlap     <= overlap_n;
         detected    <= detected_n;
         cfg_err     <= cfg_err_n;
         match_count <= count_n;
      end
   end

   assign armed = (state != UNCFG);

endmodule
